vga_color_cycler: RTL and testbench

Parametrised colour-source block for the VGA monitor path. Selects a solid display colour from a palette of up to 8 entries, stepped forward or backward by debounced push buttons or advanced automatically by a programmable timer, and drives the registered RGB bus blanked by `video_on`. Sits between the board buttons and the VGA sync generator's `video_on` output, feeding the `rgb` pins directly.

---
 rtl/vga_color_cycler.sv | 102 ++++++++++
 tb/tb_vga_color_cycler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_color_cycler.sv
// Solid-colour source for the VGA path: debounced next/prev buttons and an
// optional auto-step timer select a palette entry, output blanked by video_on.
module vga_color_cycler #(
  parameter int RGB_W           = 3,
  parameter int NUM_COLORS      = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_DIV        = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nextRgb,
  input  logic             prevRgb,
  input  logic             auto_en,
  input  logic             video_on,
  output logic [RGB_W-1:0] rgb,
  output logic [2:0]       color_idx
);

  localparam int CH_W = RGB_W / 3;
  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW   = $clog2(AUTO_DIV);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] ALAST = AW'(AUTO_DIV - 1);
  localparam logic [2:0]    ILAST = 3'(NUM_COLORS - 1);

  logic [1:0]    raw;
  logic [1:0]    sync_p0;
  logic [1:0]    sync_p1;
  logic [1:0]    lvl_p2;
  logic [1:0]    lvl_q;
  logic [DW-1:0] dcnt [2];
  logic [1:0]    press;
  logic [AW-1:0] acnt;
  logic          tick;
  logic [2:0]    idx;

  function automatic logic [2:0] inc_idx(input logic [2:0] i);
    return (i == ILAST) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic logic [2:0] dec_idx(input logic [2:0] i);
    return (i == 3'd0) ? ILAST : i - 3'd1;
  endfunction

  function automatic logic [RGB_W-1:0] palette(input logic [2:0] i);
    return {{CH_W{i[2]}}, {CH_W{i[1]}}, {CH_W{i[0]}}};
  endfunction

  // bit 0 = next button, bit 1 = prev button
  assign raw   = {prevRgb, nextRgb};
  assign press = lvl_p2 & ~lvl_q;
  assign tick  = auto_en && (acnt == ALAST);

  // p0/p1: synchroniser, p2: debounced accepted level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      lvl_p2  <= '0;
      lvl_q   <= '0;
      for (int b = 0; b < 2; b++) dcnt[b] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      lvl_q   <= lvl_p2;
      for (int b = 0; b < 2; b++) begin
        if (sync_p1[b] != lvl_p2[b]) begin
          if (dcnt[b] == DLAST) begin
            lvl_p2[b] <= ~lvl_p2[b];
            dcnt[b]   <= '0;
          end else begin
            dcnt[b] <= dcnt[b] + 1'b1;
          end
        end else begin
          dcnt[b] <= '0;
        end
      end
    end
  end

  // index update and registered colour output
  always_ff @(posedge clk) begin
    if (reset) begin
      acnt <= '0;
      idx  <= '0;
      rgb  <= '0;
    end else begin
      if ((|press) || !auto_en || tick) acnt <= '0;
      else                              acnt <= acnt + 1'b1;

      if (press[0] && press[1]) idx <= idx;
      else if (press[0])        idx <= inc_idx(idx);
      else if (press[1])        idx <= dec_idx(idx);
      else if (tick)            idx <= inc_idx(idx);

      rgb <= video_on ? palette(idx) : '0;
    end
  end

  assign color_idx = idx;

endmodule

// File: tb/tb_vga_color_cycler.sv
// Scoreboard bench for vga_color_cycler: 12-bit RGB, 6 colours, short
// debounce and auto-step periods so every path is reachable quickly.
module tb_vga_color_cycler;
  localparam int RGB_W = 12;
  localparam int NC    = 6;
  localparam int DB    = 4;
  localparam int AD    = 10;

  logic             clk = 1'b0;
  logic             reset, nextRgb, prevRgb, auto_en, video_on;
  logic [RGB_W-1:0] rgb;
  logic [2:0]       color_idx;

  typedef struct packed {
    logic [2:0]       idx;
    logic [RGB_W-1:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_idx = 0;

  vga_color_cycler #(.RGB_W(RGB_W), .NUM_COLORS(NC), .DEBOUNCE_CYCLES(DB), .AUTO_DIV(AD)) dut (
    .clk(clk), .reset(reset), .nextRgb(nextRgb), .prevRgb(prevRgb),
    .auto_en(auto_en), .video_on(video_on), .rgb(rgb), .color_idx(color_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [RGB_W-1:0] pal(input int i);
    logic [RGB_W-1:0] r;
    r = '0;
    if ((i & 4) != 0) r[11:8] = 4'hF;
    if ((i & 2) != 0) r[7:4]  = 4'hF;
    if ((i & 1) != 0) r[3:0]  = 4'hF;
    return r;
  endfunction

  function automatic int nxt(input int i);
    return (i == NC - 1) ? 0 : i + 1;
  endfunction

  function automatic int prv(input int i);
    return (i == 0) ? NC - 1 : i - 1;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Unchecked press used to move the index to a known starting point.
  task automatic press_next();
    nextRgb = 1'b1;
    step(DB + 5);
    exp_idx = nxt(exp_idx);
    nextRgb = 1'b0;
    step(DB + 5);
  endtask

  task automatic test_reset();
    reset = 1'b1; nextRgb = 1'b0; prevRgb = 1'b0; auto_en = 1'b0; video_on = 1'b1;
    step(1);
    n_cmp++;
    if (color_idx !== 3'd0) begin n_bad++; $display("FAIL reset_idx: got %0d expected 0", color_idx); end
    n_cmp++;
    if (rgb !== '0) begin n_bad++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
    step(2);
    reset = 1'b0;
    exp_idx = 0;
    step(2);
  endtask

  task automatic test_forward_wrap();
    exp_t e;
    int   old;
    for (int p = 0; p < NC; p++) begin
      old = exp_idx;
      nextRgb = 1'b1;
      exp_idx = nxt(exp_idx);
      exp_q.push_back('{idx: 3'(exp_idx), rgb: pal(exp_idx)});
      step(DB + 2);
      n_cmp++;
      if (color_idx !== 3'(old)) begin n_bad++; $display("FAIL fwd_early%0d: got %0d expected %0d", p, color_idx, old); end
      step(1);
      e = exp_q.pop_front();
      n_cmp++;
      if (color_idx !== e.idx) begin n_bad++; $display("FAIL fwd_idx%0d: got %0d expected %0d", p, color_idx, e.idx); end
      step(1);
      n_cmp++;
      if (rgb !== e.rgb) begin n_bad++; $display("FAIL fwd_rgb%0d: got %h expected %h", p, rgb, e.rgb); end
      nextRgb = 1'b0;
      step(DB + 6);
      n_cmp++;
      if (color_idx !== e.idx) begin n_bad++; $display("FAIL fwd_release%0d: got %0d expected %0d", p, color_idx, e.idx); end
    end
  endtask

  task automatic test_reset_mid();
    repeat (5) press_next();
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL pre_reset_idx: got %0d expected %0d", color_idx, exp_idx); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    exp_idx = 0;
    n_cmp++;
    if (color_idx !== 3'd0) begin n_bad++; $display("FAIL mid_reset_idx: got %0d expected 0", color_idx); end
    n_cmp++;
    if (rgb !== '0) begin n_bad++; $display("FAIL mid_reset_rgb: got %h expected 000", rgb); end
    step(20);
    n_cmp++;
    if (color_idx !== 3'd0) begin n_bad++; $display("FAIL post_reset_idx: got %0d expected 0", color_idx); end
    n_cmp++;
    if (rgb !== pal(0)) begin n_bad++; $display("FAIL post_reset_rgb: got %h expected %h", rgb, pal(0)); end
  endtask

  task automatic test_backward_bounce();
    for (int i = 0; i < 10; i++) begin
      prevRgb = ((i / 2) % 2) == 0;
      step(1);
    end
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL bounce_idx: got %0d expected %0d", color_idx, exp_idx); end
    prevRgb = 1'b1;
    exp_idx = prv(exp_idx);
    step(10);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL prev_wrap_idx: got %0d expected %0d", color_idx, exp_idx); end
    prevRgb = 1'b0;
    step(20);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL prev_release_idx: got %0d expected %0d", color_idx, exp_idx); end
  endtask

  task automatic test_simultaneous();
    repeat (4) press_next();
    n_cmp++;
    if (color_idx !== 3'd3) begin n_bad++; $display("FAIL simul_start: got %0d expected 3", color_idx); end
    auto_en = 1'b1; nextRgb = 1'b1; prevRgb = 1'b1;
    step(7);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL simul_idx: got %0d expected %0d", color_idx, exp_idx); end
    step(3);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL simul_acnt_clear: got %0d expected %0d", color_idx, exp_idx); end
    step(6);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL simul_pre_tick: got %0d expected %0d", color_idx, exp_idx); end
    step(1);
    exp_idx = nxt(exp_idx);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL simul_tick: got %0d expected %0d", color_idx, exp_idx); end
    auto_en = 1'b0; nextRgb = 1'b0; prevRgb = 1'b0;
    step(15);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL simul_release: got %0d expected %0d", color_idx, exp_idx); end
  endtask

  task automatic test_auto_override();
    auto_en = 1'b1;
    step(AD - 1);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL auto_pre: got %0d expected %0d", color_idx, exp_idx); end
    step(1);
    exp_idx = nxt(exp_idx);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL auto_step1: got %0d expected %0d", color_idx, exp_idx); end
    step(AD);
    exp_idx = nxt(exp_idx);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL auto_step2: got %0d expected %0d", color_idx, exp_idx); end
    step(3);
    nextRgb = 1'b1;
    step(6);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL override_pre: got %0d expected %0d", color_idx, exp_idx); end
    step(1);
    exp_idx = nxt(exp_idx);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL override_single: got %0d expected %0d", color_idx, exp_idx); end
    step(AD - 1);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL override_hold: got %0d expected %0d", color_idx, exp_idx); end
    step(1);
    exp_idx = nxt(exp_idx);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL override_next_tick: got %0d expected %0d", color_idx, exp_idx); end
    auto_en = 1'b0; nextRgb = 1'b0;
    step(25);
    n_cmp++;
    if (color_idx !== 3'(exp_idx)) begin n_bad++; $display("FAIL auto_off: got %0d expected %0d", color_idx, exp_idx); end
  endtask

  task automatic test_blanking();
    exp_t e;
    logic v;
    while (exp_idx != 5) press_next();
    for (int i = 0; i < 16; i++) begin
      v = (i < 8) ? ((i % 2) == 0) : 1'($urandom_range(0, 1));
      video_on = v;
      exp_q.push_back('{idx: 3'(exp_idx), rgb: v ? pal(exp_idx) : '0});
      step(1);
      e = exp_q.pop_front();
      n_cmp++;
      if (rgb !== e.rgb) begin n_bad++; $display("FAIL blank_rgb%0d: got %h expected %h", i, rgb, e.rgb); end
    end
    video_on = 1'b1;
    step(1);
  endtask

  initial begin
    test_reset();
    test_forward_wrap();
    test_reset_mid();
    test_backward_bounce();
    test_simultaneous();
    test_auto_override();
    test_blanking();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
